// File: rtl/vga_pkg.sv
// Shared VGA pipeline types: counter/colour widths and the timing-strobe bundle.
package vga_pkg;

  localparam int unsigned HCOUNT_W   = 11;
  localparam int unsigned VCOUNT_W   = 11;
  localparam int unsigned RGB_W      = 12;
  localparam int unsigned ROM_ADDR_W = 12;
  localparam int unsigned OFF_W      = 6;

  typedef struct packed {
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    logic                hsync;
    logic                vsync;
    logic                hblnk;
    logic                vblnk;
  } vga_timing_t;

  // One pixel travelling down the sprite pipeline.
  typedef struct packed {
    vga_timing_t          timing;
    logic [RGB_W-1:0]     rgb;
    logic                 in_sprite;
  } pix_pipe_t;

endpackage

// File: rtl/delay.sv
// Parameterised shift register, CLK_DEL stages of WIDTH bits, async reset to zero.
module delay #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [CLK_DEL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CLK_DEL); i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < int'(CLK_DEL); i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[CLK_DEL-1];

endmodule

// File: rtl/sprite_draw.sv
// Sprite overlay stage: addresses a 1-cycle-latency image ROM and composites it over rgb_in.
// Define TRANSPARENCY_EN to let TRANSPARENT_COLOR ROM pixels show the background.
module sprite_draw
  import vga_pkg::*;
#(
  parameter int unsigned SPRITE_W          = 48,
  parameter int unsigned SPRITE_H          = 64,
  parameter logic [11:0] TRANSPARENT_COLOR = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

`ifdef TRANSPARENCY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic [HCOUNT_W-1:0] xpos_q;
  logic [VCOUNT_W-1:0] ypos_q;

  // Sprite position only moves at frame start so a frame is never torn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xpos_q <= '0;
      ypos_q <= '0;
    end else if (hcount_in == '0 && vcount_in == '0) begin
      xpos_q <= xpos;
      ypos_q <= ypos;
    end
  end

  logic [HCOUNT_W:0]   x_end_c;
  logic [VCOUNT_W:0]   y_end_c;
  logic [OFF_W-1:0]    x_off_c;
  logic [OFF_W-1:0]    y_off_c;
  logic                in_sprite_c;

  // One extra bit on the far edge keeps sprites near 2047 clipped rather than wrapped.
  assign x_end_c = {1'b0, xpos_q} + (HCOUNT_W+1)'(SPRITE_W);
  assign y_end_c = {1'b0, ypos_q} + (VCOUNT_W+1)'(SPRITE_H);
  assign x_off_c = OFF_W'(hcount_in - xpos_q);
  assign y_off_c = OFF_W'(vcount_in - ypos_q);

  assign in_sprite_c = (hcount_in >= xpos_q) && ({1'b0, hcount_in} < x_end_c) &&
                       (vcount_in >= ypos_q) && ({1'b0, vcount_in} < y_end_c) &&
                       !hblnk_in && !vblnk_in;

  pix_pipe_t pipe_in_c;
  pix_pipe_t pipe_d2;

  assign pipe_in_c = '{
    timing: '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
              vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in},
    rgb: rgb_in,
    in_sprite: in_sprite_c
  };

  // Two stages here plus the output register give the fixed 3-cycle latency.
  delay #(
    .WIDTH  ($bits(pix_pipe_t)),
    .CLK_DEL(2)
  ) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (pipe_in_c),
    .dout (pipe_d2)
  );

  logic blank_d2_c;
  logic show_rom_c;

  assign blank_d2_c = pipe_d2.timing.hblnk || pipe_d2.timing.vblnk;
  assign show_rom_c = pipe_d2.in_sprite && !(KEY_EN && (rom_rgb == TRANSPARENT_COLOR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr   <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      rom_addr   <= in_sprite_c ? {y_off_c, x_off_c} : '0;
      hcount_out <= pipe_d2.timing.hcount;
      vcount_out <= pipe_d2.timing.vcount;
      hsync_out  <= pipe_d2.timing.hsync;
      vsync_out  <= pipe_d2.timing.vsync;
      hblnk_out  <= pipe_d2.timing.hblnk;
      vblnk_out  <= pipe_d2.timing.vblnk;
      if (blank_d2_c)      rgb_out <= '0;
      else if (show_rom_c) rgb_out <= rom_rgb;
      else                 rgb_out <= pipe_d2.rgb;
    end
  end

endmodule
